// File: rtl/rchdc_seq_if.sv
// Command, feature-stream and result bundle between a host and the Rchdc batch sequencer.
// The sequencer is the slave; the host driving commands and features is the master.
interface rchdc_seq_if #(
    parameter int CLS_DW    = 5,
    parameter int SMP_CNT_W = 16,
    parameter int FIDX_W    = 10
);
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic                 cmd_mode;
    logic [SMP_CNT_W-1:0] cmd_num;

    logic                 feat_valid;
    logic                 feat_ready;
    logic [CLS_DW-1:0]    feat_label;
    logic [FIDX_W-1:0]    feat_idx;

    logic                 res_valid;
    logic [CLS_DW-1:0]    res_class;
    logic [SMP_CNT_W-1:0] res_idx;

    modport slave (
        input  cmd_valid, cmd_mode, cmd_num,
        output cmd_ready,
        input  feat_valid, feat_label,
        output feat_ready, feat_idx,
        output res_valid, res_class, res_idx
    );

    modport master (
        output cmd_valid, cmd_mode, cmd_num,
        input  cmd_ready,
        output feat_valid, feat_label,
        input  feat_ready, feat_idx,
        input  res_valid, res_class, res_idx
    );
endinterface

// File: rtl/rchdc_seq.sv
// Batch sequencer for the Rchdc classifier core: paces feature beats, generates the core's
// sample/set strobes and returns one tagged class result per sample in predict mode.
module rchdc_seq #(
    parameter int FEAT_NUM  = 617,
    parameter int CLS_NUM   = 26,
    parameter int CLS_DW    = $clog2(CLS_NUM),
    parameter int SMP_CNT_W = 16,
    parameter int PRED_LAT  = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    rchdc_seq_if.slave        bus,
    output logic              state,
    output logic              smp_en,
    output logic              smp_clr,
    output logic              set_clr,
    output logic [CLS_DW-1:0] label,
    input  logic [CLS_DW-1:0] predict,
    output logic              busy,
    output logic              done
);
    localparam int FIDX_W = $clog2(FEAT_NUM);
    localparam logic [FIDX_W-1:0] FIDX_LAST = FIDX_W'(FEAT_NUM - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FEED  = 3'd1;
    localparam logic [2:0] S_CLR   = 3'd2;
    localparam logic [2:0] S_SET   = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;

    logic [2:0]           st_q, st_d;
    logic                 mode_q, mode_d;
    logic [SMP_CNT_W-1:0] num_q, num_d;
    logic [SMP_CNT_W-1:0] cnt_q, cnt_d;
    logic [FIDX_W-1:0]    fidx_q, fidx_d;
    logic [CLS_DW-1:0]    label_q, label_d;
    logic                 done_q, done_d;
    logic                 dl_vld_q [PRED_LAT];
    logic                 dl_vld_d [PRED_LAT];
    logic [SMP_CNT_W-1:0] dl_idx_q [PRED_LAT];
    logic [SMP_CNT_W-1:0] dl_idx_d [PRED_LAT];
    logic                 push;
    logic                 pending;
    logic                 last_smp;

    always_comb begin
        st_d     = st_q;
        mode_d   = mode_q;
        num_d    = num_q;
        cnt_d    = cnt_q;
        fidx_d   = fidx_q;
        label_d  = label_q;
        done_d   = 1'b0;
        push     = 1'b0;
        last_smp = (cnt_q == num_q - SMP_CNT_W'(1));

        // The last stage retires this cycle, so DRAIN only waits on the earlier stages;
        // that makes done land one cycle after the final res_valid.
        pending = 1'b0;
        for (int unsigned i = 0; i + 1 < PRED_LAT; i++) begin
            pending = pending | dl_vld_q[i];
        end

        case (st_q)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    mode_d = bus.cmd_mode;
                    num_d  = bus.cmd_num;
                    fidx_d = '0;
                    cnt_d  = '0;
                    if (bus.cmd_num == '0) done_d = 1'b1;
                    else                   st_d   = S_FEED;
                end
            end
            S_FEED: begin
                if (bus.feat_valid) begin
                    if (fidx_q == '0) label_d = bus.feat_label;
                    if (fidx_q == FIDX_LAST) begin
                        fidx_d = '0;
                        st_d   = S_CLR;
                    end else begin
                        fidx_d = fidx_q + FIDX_W'(1);
                    end
                end
            end
            S_CLR: begin
                cnt_d = cnt_q + SMP_CNT_W'(1);
                push  = mode_q;
                if (last_smp) st_d = mode_q ? S_DRAIN : S_SET;
                else          st_d = S_FEED;
            end
            S_SET: begin
                st_d   = S_IDLE;
                done_d = 1'b1;
            end
            S_DRAIN: begin
                if (!pending) begin
                    st_d   = S_IDLE;
                    done_d = 1'b1;
                end
            end
            default: st_d = S_IDLE;
        endcase

        dl_vld_d[0] = push;
        dl_idx_d[0] = cnt_q;
        for (int unsigned i = 1; i < PRED_LAT; i++) begin
            dl_vld_d[i] = dl_vld_q[i-1];
            dl_idx_d[i] = dl_idx_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q     <= S_IDLE;
            mode_q   <= 1'b0;
            num_q    <= '0;
            cnt_q    <= '0;
            fidx_q   <= '0;
            label_q  <= '0;
            done_q   <= 1'b0;
            dl_vld_q <= '{default: 1'b0};
            dl_idx_q <= '{default: '0};
        end else begin
            st_q     <= st_d;
            mode_q   <= mode_d;
            num_q    <= num_d;
            cnt_q    <= cnt_d;
            fidx_q   <= fidx_d;
            label_q  <= label_d;
            done_q   <= done_d;
            dl_vld_q <= dl_vld_d;
            dl_idx_q <= dl_idx_d;
        end
    end

    assign bus.cmd_ready  = (st_q == S_IDLE);
    assign bus.feat_ready = (st_q == S_FEED);
    assign bus.feat_idx   = fidx_q;
    assign bus.res_valid  = dl_vld_q[PRED_LAT-1];
    assign bus.res_idx    = dl_vld_q[PRED_LAT-1] ? dl_idx_q[PRED_LAT-1] : '0;
    assign bus.res_class  = dl_vld_q[PRED_LAT-1] ? predict : '0;

    assign smp_en  = (st_q == S_FEED) && bus.feat_valid;
    assign smp_clr = (st_q == S_CLR);
    assign set_clr = (st_q == S_SET);
    assign busy    = (st_q != S_IDLE);
    assign done    = done_q;
    assign state   = mode_q;
    assign label   = label_q;
endmodule

// File: tb/tb_rchdc_seq.sv
// Directed-plus-random bench for rchdc_seq: a per-batch schedule is derived from the
// beat pattern and compared cycle by cycle against every DUT output.
module tb_rchdc_seq;
    localparam int FEAT = 4;
    localparam int PL   = 3;
    localparam int CDW  = 5;
    localparam int SW   = 16;
    localparam int FW   = 2;
    localparam int MAXC = 1024;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           state, smp_en, smp_clr, set_clr, busy, done;
    logic [CDW-1:0] label;
    logic [CDW-1:0] predict;

    int n_assert = 0;
    int n_fail   = 0;

    rchdc_seq_if #(.CLS_DW(CDW), .SMP_CNT_W(SW), .FIDX_W(FW)) bus ();

    rchdc_seq #(
        .FEAT_NUM (FEAT),
        .CLS_NUM  (26),
        .SMP_CNT_W(SW),
        .PRED_LAT (PL)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus    (bus),
        .state  (state),
        .smp_en (smp_en),
        .smp_clr(smp_clr),
        .set_clr(set_clr),
        .label  (label),
        .predict(predict),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    // stimulus per cycle of a batch (cycle 0 = accept cycle)
    bit             vpat [MAXC];
    logic [CDW-1:0] lab  [MAXC];
    logic [CDW-1:0] pred [MAXC];

    // expected outputs per cycle
    bit             e_fr [MAXC], e_en [MAXC], e_clr [MAXC], e_set [MAXC];
    bit             e_rv [MAXC], e_busy [MAXC], e_done [MAXC];
    int             e_fidx [MAXC], e_ridx [MAXC];
    logic [CDW-1:0] e_lab [MAXC];
    int             done_c, abort_c, obs_done_c;
    bit             state_m = 1'b0;
    logic [CDW-1:0] label_m = '0;

    task automatic chk(input string tag, input int c, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s @cycle %0d: observed=%0h expected=%0h", tag, c, obs, exp);
        end
    endtask

    task automatic prep(input int pat);
        for (int c = 0; c < MAXC; c++) begin
            if (pat == 1)      vpat[c] = 1'b1;
            else if (pat == 2) vpat[c] = (c % 2 == 1);
            else               vpat[c] = ($urandom_range(0, 1) == 1) || (c >= 200);
            lab[c]  = CDW'($urandom_range(0, 25));
            pred[c] = CDW'($urandom_range(0, 25));
        end
    endtask

    // Walk the samples: FEAT valid beats each, then one clear cycle; results PL cycles later.
    task automatic build(input bit mode, input int num);
        int c, b, lc, first_clr;
        for (int k = 0; k < MAXC; k++) begin
            e_fr[k] = 0; e_en[k] = 0; e_clr[k] = 0; e_set[k] = 0; e_rv[k] = 0;
            e_busy[k] = 0; e_done[k] = 0; e_fidx[k] = 0; e_ridx[k] = 0; e_lab[k] = '0;
        end
        state_m   = mode;
        c         = 1;
        lc        = 0;
        first_clr = -1;
        for (int s = 0; s < num; s++) begin
            b = 0;
            while (b < FEAT) begin
                e_busy[c] = 1; e_fr[c] = 1; e_fidx[c] = b; e_lab[c] = label_m;
                if (vpat[c]) begin
                    e_en[c] = 1;
                    if (b == 0) label_m = lab[c];
                    b++;
                end
                c++;
            end
            e_busy[c] = 1; e_clr[c] = 1; e_lab[c] = label_m;
            if (first_clr < 0) first_clr = c;
            if (mode) begin
                e_rv[c+PL] = 1;
                e_ridx[c+PL] = s;
            end
            lc = c;
            c++;
        end
        if (num == 0) begin
            done_c = 1;
        end else if (!mode) begin
            e_busy[c] = 1; e_set[c] = 1; e_lab[c] = label_m;
            c++;
            done_c = c;
        end else begin
            while (c <= lc + PL) begin
                e_busy[c] = 1; e_lab[c] = label_m;
                c++;
            end
            done_c = c;
        end
        e_done[done_c] = 1;
        e_lab[done_c]  = label_m;
        abort_c = first_clr + 1;
    endtask

    task automatic reset_seq();
        rst_n = 1'b0;
        bus.feat_valid = 1'b1;
        predict = CDW'(9);
        #1;
        chk("rst_cmd_ready", 0, 32'(bus.cmd_ready), 32'd1);
        chk("rst_feat_ready", 0, 32'(bus.feat_ready), 32'd0);
        chk("rst_feat_idx", 0, 32'(bus.feat_idx), 32'd0);
        chk("rst_state", 0, 32'(state), 32'd0);
        chk("rst_smp_en", 0, 32'(smp_en), 32'd0);
        chk("rst_smp_clr", 0, 32'(smp_clr), 32'd0);
        chk("rst_set_clr", 0, 32'(set_clr), 32'd0);
        chk("rst_label", 0, 32'(label), 32'd0);
        chk("rst_res_valid", 0, 32'(bus.res_valid), 32'd0);
        chk("rst_res_class", 0, 32'(bus.res_class), 32'd0);
        chk("rst_res_idx", 0, 32'(bus.res_idx), 32'd0);
        chk("rst_busy", 0, 32'(busy), 32'd0);
        chk("rst_done", 0, 32'(done), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        state_m = 1'b0;
        label_m = '0;
        bus.cmd_valid = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            bus.feat_valid = ($urandom_range(0, 1) == 1);
            @(negedge clk);
            chk("post_rst_res_valid", k, 32'(bus.res_valid), 32'd0);
            chk("post_rst_done", k, 32'(done), 32'd0);
            chk("post_rst_feat_idx", k, 32'(bus.feat_idx), 32'd0);
            chk("post_rst_cmd_ready", k, 32'(bus.cmd_ready), 32'd1);
            chk("post_rst_smp_en", k, 32'(smp_en), 32'd0);
            @(posedge clk); #1;
        end
    endtask

    task automatic run_batch(input bit mode, input int num, input bit skip_acc, input bit hold,
                             input bit nxt_v, input bit nxt_mode, input int nxt_num, input bit abort);
        build(mode, num);
        obs_done_c = -1;
        if (!skip_acc) begin
            bus.cmd_valid = 1'b1; bus.cmd_mode = mode; bus.cmd_num = SW'(num);
            bus.feat_valid = vpat[0]; bus.feat_label = lab[0]; predict = pred[0];
            @(negedge clk);
            chk("accept_ready", 0, 32'(bus.cmd_ready), 32'd1);
            @(posedge clk); #1;
        end
        for (int c = 1; c <= done_c; c++) begin
            bus.cmd_valid = hold;
            bus.cmd_mode  = ($urandom_range(0, 1) == 1);
            bus.cmd_num   = SW'($urandom_range(1, 3));
            if (c == done_c) begin
                bus.cmd_valid = nxt_v; bus.cmd_mode = nxt_mode; bus.cmd_num = SW'(nxt_num);
            end
            bus.feat_valid = vpat[c]; bus.feat_label = lab[c]; predict = pred[c];
            if (abort && c == abort_c) begin
                bus.cmd_valid = 1'b0;
                reset_seq();
                return;
            end
            @(negedge clk);
            chk("cmd_ready", c, 32'(bus.cmd_ready), 32'(!e_busy[c]));
            chk("feat_ready", c, 32'(bus.feat_ready), 32'(e_fr[c]));
            chk("feat_idx", c, 32'(bus.feat_idx), 32'(e_fidx[c]));
            chk("state", c, 32'(state), 32'(state_m));
            chk("smp_en", c, 32'(smp_en), 32'(e_en[c]));
            chk("smp_clr", c, 32'(smp_clr), 32'(e_clr[c]));
            chk("set_clr", c, 32'(set_clr), 32'(e_set[c]));
            chk("label", c, 32'(label), 32'(e_lab[c]));
            chk("res_valid", c, 32'(bus.res_valid), 32'(e_rv[c]));
            chk("res_class", c, 32'(bus.res_class), e_rv[c] ? 32'(pred[c]) : 32'd0);
            chk("res_idx", c, 32'(bus.res_idx), 32'(e_ridx[c]));
            chk("busy", c, 32'(busy), 32'(e_busy[c]));
            chk("done", c, 32'(done), 32'(e_done[c]));
            if (done === 1'b1 && obs_done_c < 0) obs_done_c = c;
            @(posedge clk); #1;
        end
        bus.cmd_valid = 1'b0;
    endtask

    initial begin
        bus.cmd_valid = 1'b0; bus.cmd_mode = 1'b0; bus.cmd_num = '0;
        bus.feat_valid = 1'b0; bus.feat_label = '0; predict = '0;
        repeat (2) @(posedge clk);
        #1;
        reset_seq();

        // TRAIN, continuous stream, labels 5 then 7
        prep(1);
        lab[1] = CDW'(5);
        lab[6] = CDW'(7);
        run_batch(1'b0, 2, 0, 0, 0, 0, 0, 0);
        chk("train_accept_to_done", 0, 32'(obs_done_c), 32'(2 * (FEAT + 1) + 2));

        // PREDICT, gapped stream
        prep(2);
        run_batch(1'b1, 3, 0, 0, 0, 0, 0, 0);

        // empty batch
        prep(0);
        run_batch(1'b1, 0, 0, 0, 0, 0, 0, 0);

        // reset during FEED of sample 1 with one result in flight
        prep(1);
        run_batch(1'b1, 3, 0, 0, 0, 0, 0, 1);

        // command held while busy, then back-to-back accept in the done cycle
        prep(0);
        run_batch(1'b0, 2, 0, 1, 1, 1'b1, 2, 0);
        prep(0);
        run_batch(1'b1, 2, 1, 0, 0, 0, 0, 0);

        // random batches
        for (int r = 0; r < 6; r++) begin
            prep(0);
            run_batch(($urandom_range(0, 1) == 1), $urandom_range(1, 4), 0, 0, 0, 0, 0, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/rchdc_seq.md
# rchdc_seq

Batch sequencer for the Rchdc classifier core. It accepts train or predict commands and paces the external feature stream into the core. It generates the core's control strobes: `smp_en`, `smp_clr`, `set_clr`, `state` and `label`. In predict mode it returns one tagged class result per sample.

## Interface

Parameters:
- `FEAT_NUM`, 617: features per sample; feature beats per `smp_clr`.
- `CLS_NUM`, 26: number of classes.
- `CLS_DW`, `$clog2(CLS_NUM)`: class/label width.
- `SMP_CNT_W`, 16: sample-count width.
- `PRED_LAT`, 3: cycles from a predict-mode `smp_clr` to a valid `predict` from the core (Similarity + FindMin). Must be ≥1.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: one clock; reset is asynchronous and active-low.
- `cmd_valid` in 1: command request.
- `cmd_ready` out 1: sequencer idle, command accepted on `cmd_valid && cmd_ready`.
- `cmd_mode` in 1: 0 = TRAIN, 1 = PREDICT.
- `cmd_num` in SMP_CNT_W: samples in the batch.
- `feat_valid` in 1: feature beat available (data routed directly to core).
- `feat_ready` out 1: sequencer consumes beat.
- `feat_label` in CLS_DW: sample label, sampled on the beat with `feat_idx==0`.
- `feat_idx` out `$clog2(FEAT_NUM)`: index of the expected beat; addresses the position item memory.
- `state` out 1: core mode, equals latched `cmd_mode`.
- `smp_en` out 1: core sample-encoder enable.
- `smp_clr` out 1: end-of-sample strobe.
- `set_clr` out 1: end-of-training-set strobe (AM write).
- `label` out CLS_DW: latched label of the current sample.
- `predict` in CLS_DW: core prediction.
- `res_valid` out 1: one-cycle result strobe, no backpressure.
- `res_class` out CLS_DW: `predict` sampled with `res_valid`.
- `res_idx` out SMP_CNT_W: sample index within batch of this result.
- `busy` out 1: FSM not IDLE.
- `done` out 1: one-cycle batch completion pulse.

## Operation

FSM states and transitions:
- **IDLE**: `cmd_ready=1`. On accept, latch `cmd_mode` into `state`, latch `cmd_num`, and clear `feat_idx` and the sample counter.
  - `cmd_num==0`: stay IDLE, pulse `done` next cycle.
  - Otherwise go to FEED.
- **FEED**: `feat_ready=1`; `smp_en = feat_valid` (combinational).
  - Each beat increments `feat_idx`.
  - The beat with `feat_idx==0` latches `feat_label` into `label`.
  - The beat with `feat_idx==FEAT_NUM-1` wraps `feat_idx` to 0 and goes to CLR.
  - Stalls on `feat_valid=0` hold all state.
- **CLR**: `smp_clr=1` for one cycle, `feat_ready=0`, `smp_en=0`, sample counter increments.
  - PREDICT mode: push the sample index into a PRED_LAT-deep delay line.
  - Next state when this was the last sample: TRAIN → SET, PREDICT → DRAIN.
  - Otherwise next state is FEED.
- **SET**: `set_clr=1` for one cycle, then IDLE.
- **DRAIN**: wait until the delay line is empty, then IDLE.
- **Entering IDLE** from SET or DRAIN: `done=1` in the first IDLE cycle. `cmd_ready` is also 1 in that cycle.

Result path:
- The delay-line output drives `res_valid` and `res_idx`.
- `res_class = predict` in the same cycle.
- Results overlap FEED of subsequent samples; order is preserved.

Other rules:
- `state` holds its last value in IDLE.
- `cmd_valid` while busy is ignored (`cmd_ready=0`).
- Counters are unsigned. The sample counter compares against latched `cmd_num`; no wrap within a batch.

## Timing

- Reset values:
  - All outputs 0 except `cmd_ready=1`.
  - `state=0` (TRAIN); delay line cleared.
- Asynchronous reset mid-batch:
  - Immediate return to IDLE.
  - Pending results are discarded (no `res_valid`) and no `done` is produced.
- Throughput with continuous `feat_valid`: FEAT_NUM+1 cycles per sample.
- TRAIN, from accept to `done`: `cmd_num*(FEAT_NUM+1)+2` cycles.
- PREDICT: `res_valid` for sample k occurs exactly PRED_LAT cycles after its `smp_clr`. `done` follows the last `res_valid` by one cycle.
- `label` is stable from the first beat of a sample through its `smp_clr` cycle.
- `smp_en`, `smp_clr` and `set_clr` are mutually exclusive.

## Test plan

Use FEAT_NUM=4, PRED_LAT=3 throughout.

1. **Reset:** assert `rst_n=0` mid-run → `cmd_ready=1`, all other outputs 0, `state=0`.
2. **TRAIN, continuous stream:** `cmd_num=2`, labels 5 then 7, `feat_valid` held 1 →
   - `smp_en` high cycles 1–4 and 6–9.
   - `smp_clr` at cycle 5 (`label=5`) and cycle 10 (`label=7`).
   - `set_clr` at cycle 11, `done` at cycle 12; no `res_valid`.
3. **PREDICT, gapped stream:** `cmd_num=3`, `feat_valid` toggling 1/0 →
   - `smp_en` only on valid beats; `feat_idx` holds across gaps.
   - Three `res_valid`, each 3 cycles after the matching `smp_clr`.
   - `res_idx` = 0, 1, 2; `res_class` equals the driven `predict`.
   - `done` one cycle after the last result.
4. **Empty batch:** `cmd_num=0` → `done` next cycle; no `smp_en`, `smp_clr` or `set_clr`; `busy` stays 0.
5. **Reset mid-batch:** `rst_n` low during FEED of sample 1 in PREDICT with one result pending → that result never appears; after release `feat_idx=0`, `cmd_ready=1`, `done` not pulsed.
6. **Command while busy / back-to-back:** `cmd_valid` held high while busy → ignored. The next command is accepted in the `done` cycle and its batch starts FEED on the following cycle.
